// File: rtl/fc_ram_pkg.sv
// Shared definitions for the FC layer buffer RAM and its load/compute sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   fc_ram_state_t - sequencer FSM state encoding
//   FC_RAM_DEEP    - default buffer depth in words, shared with the RAM instance
//   FC_DWIDTH      - default buffer word width
`timescale 1ns/1ps

package fc_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_FLUSH = 2'd3
  } fc_ram_state_t;

  localparam int FC_RAM_DEEP = 40;
  localparam int FC_DWIDTH   = 16;

endpackage

// File: rtl/fc_ram_sched.sv
// Load/compute sequencer for the FC layer dual-port buffer RAM.
// Latency: load writes in the accept cycle; read word k returns 1 cycle after its issue, done 1 cycle after the last word.
// Backpressure: s_ready drops only when rd_start wins in IDLE or outside IDLE/LOAD; the read stream has none.
//
// Ports:
//   clk, rst                         - clock, async active-high reset
//   s_valid/s_ready/s_data/s_last    - load word stream (port A writes)
//   rd_start/rd_base/rd_len          - read command, sampled only in IDLE
//   busy, done                       - FSM not idle; one-cycle end-of-read pulse
//   loaded_cnt, ovf                  - words stored by the last burst; sticky burst overflow
//   m_valid/m_data/m_last            - read stream to the MAC datapath
//   ram_wea/ram_addra/ram_dina/ram_rea - RAM port A (write only)
//   ram_reb/ram_addrb/ram_web        - RAM port B (read only)
//   ram_doutb/ram_dvalidb            - RAM port B return, one-cycle latency
`timescale 1ns/1ps

module fc_ram_sched
  import fc_ram_pkg::*;
#(
  parameter int RAM_DEEP = FC_RAM_DEEP,
  parameter int DWIDTH   = FC_DWIDTH,
  parameter int AWIDTH   = $clog2(RAM_DEEP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWIDTH-1:0] s_data,
  input  logic              s_last,
  input  logic              rd_start,
  input  logic [AWIDTH-1:0] rd_base,
  input  logic [AWIDTH:0]   rd_len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH:0]   loaded_cnt,
  output logic              ovf,
  output logic              m_valid,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last,
  output logic              ram_wea,
  output logic [AWIDTH-1:0] ram_addra,
  output logic [DWIDTH-1:0] ram_dina,
  output logic              ram_rea,
  output logic              ram_reb,
  output logic [AWIDTH-1:0] ram_addrb,
  output logic              ram_web,
  input  logic [DWIDTH-1:0] ram_doutb,
  input  logic              ram_dvalidb
);

  localparam logic [AWIDTH:0]   DEEP_W = (AWIDTH+1)'(RAM_DEEP);
  localparam logic [AWIDTH:0]   ONE_W  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] LAST_A = AWIDTH'(RAM_DEEP - 1);

  fc_ram_state_t     r_state;
  logic [AWIDTH:0]   r_wr_ptr;
  logic [AWIDTH:0]   r_loaded_cnt;
  logic              r_ovf;
  logic [AWIDTH-1:0] r_rd_addr;
  logic [AWIDTH:0]   r_rd_idx;
  logic [AWIDTH:0]   r_rd_len;
  logic              r_done;

  logic              w_idle;
  logic              w_load;
  logic              w_beat;
  logic              w_wr_en;
  logic [AWIDTH-1:0] w_wr_addr;
  logic [AWIDTH:0]   w_len_clamp;
  logic [AWIDTH:0]   w_base_ext;
  logic [AWIDTH-1:0] w_base_norm;
  logic              w_rd_live;

  assign w_idle = (r_state == ST_IDLE);
  assign w_load = (r_state == ST_LOAD);

  // rst is folded in so every output reads 0 while reset is held.
  assign s_ready = !rst && ((w_idle && !rd_start) || w_load);
  assign w_beat  = s_valid && s_ready;

  // The first beat of a burst is taken in IDLE and always lands at address 0;
  // beats past the end of the RAM are accepted but dropped.
  assign w_wr_en   = w_beat && (w_idle || (r_wr_ptr < DEEP_W));
  assign w_wr_addr = w_idle ? '0 : r_wr_ptr[AWIDTH-1:0];

  assign w_len_clamp = (rd_len > DEEP_W) ? DEEP_W : rd_len;
  assign w_base_ext  = {1'b0, rd_base};
  assign w_base_norm = (w_base_ext >= DEEP_W) ? AWIDTH'(w_base_ext - DEEP_W) : rd_base;

  assign ram_wea   = w_wr_en;
  assign ram_addra = w_wr_en ? w_wr_addr : '0;
  assign ram_dina  = w_wr_en ? s_data : '0;
  assign ram_rea   = 1'b0;
  assign ram_web   = 1'b0;

  assign ram_reb   = !rst && (r_state == ST_READ);
  assign ram_addrb = ram_reb ? r_rd_addr : '0;

  // Returns are only meaningful while a command is in flight; anything that
  // arrives in IDLE (e.g. the tail of a read cut off by reset) is masked.
  assign w_rd_live = !rst && ((r_state == ST_READ) || (r_state == ST_FLUSH));
  assign m_valid   = w_rd_live && ram_dvalidb;
  assign m_data    = m_valid ? ram_doutb : '0;
  // Issues are back-to-back, so the only return seen in FLUSH is the final word.
  assign m_last    = m_valid && (r_state == ST_FLUSH);

  assign busy       = !w_idle;
  assign done       = r_done;
  assign loaded_cnt = r_loaded_cnt;
  assign ovf        = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_loaded_cnt <= '0;
      r_ovf        <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_idx     <= '0;
      r_rd_len     <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (rd_start) begin
            if (rd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rd_addr <= w_base_norm;
              r_rd_len  <= w_len_clamp;
              r_rd_idx  <= '0;
              r_state   <= ST_READ;
            end
          end else if (s_valid) begin
            r_wr_ptr <= ONE_W;
            r_ovf    <= 1'b0;
            if (s_last) begin
              r_loaded_cnt <= ONE_W;
            end else begin
              r_state <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          if (w_beat) begin
            if (w_wr_en) begin
              r_wr_ptr <= r_wr_ptr + ONE_W;
            end else begin
              r_ovf <= 1'b1;
            end
            if (s_last) begin
              r_loaded_cnt <= w_wr_en ? (r_wr_ptr + ONE_W) : r_wr_ptr;
              r_state      <= ST_IDLE;
            end
          end
        end

        ST_READ: begin
          r_rd_addr <= (r_rd_addr == LAST_A) ? '0 : (r_rd_addr + AWIDTH'(1));
          r_rd_idx  <= r_rd_idx + ONE_W;
          if (r_rd_idx == (r_rd_len - ONE_W)) begin
            r_state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b1;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_ram_sched.sv
// Bench for fc_ram_sched: RAM model on both ports, reference buffer image, read-stream scoreboard.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_fc_ram_sched;
  import fc_ram_pkg::*;

  localparam int DEEP = 40;
  localparam int DW   = 16;
  localparam int AW   = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last;
  logic [DW-1:0] s_data;
  logic          rd_start;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic          busy, done, ovf;
  logic [AW:0]   loaded_cnt;
  logic          m_valid, m_last;
  logic [DW-1:0] m_data;
  logic          ram_wea, ram_rea, ram_reb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_doutb = '0;
  logic          ram_dvalidb = 1'b0;

  always #5 clk = ~clk;

  fc_ram_sched #(.RAM_DEEP(DEEP), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .busy(busy), .done(done), .loaded_cnt(loaded_cnt), .ovf(ovf),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_rea(ram_rea),
    .ram_reb(ram_reb), .ram_addrb(ram_addrb), .ram_web(ram_web),
    .ram_doutb(ram_doutb), .ram_dvalidb(ram_dvalidb)
  );

  // External dual-port RAM with one-cycle read latency.
  logic [DW-1:0] mem [DEEP];
  always @(posedge clk) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    ram_dvalidb <= ram_reb;
    if (ram_reb) ram_doutb <= mem[ram_addrb];
  end

  // Reference image of what the buffer should hold, built from the load rules.
  logic [DW-1:0] ref_mem [DEEP];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every presented read word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("m_data", m_data, mon_e.d);
        chk("m_last", m_last, mon_e.l);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_ram_reb"}, ram_reb, 0);
    chk({tag, "_ram_addrb"}, ram_addrb, 0);
    chk({tag, "_ram_wea"}, ram_wea, 0);
    chk({tag, "_loaded_cnt"}, loaded_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  // Load burst of n beats, one per cycle; entered and left at posedge+1.
  task automatic do_load(input int n, input bit rnd, input logic [DW-1:0] start);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? DW'($urandom) : start + DW'(i);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = (i == n - 1);
      #1;
      chk("load_s_ready", s_ready, 1);
      chk("load_wea", ram_wea, (i < DEEP));
      if (i < DEEP) begin
        chk("load_addra", ram_addra, i);
        chk("load_dina", ram_dina, d);
        ref_mem[i] = d;
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("load_cnt", loaded_cnt, (n < DEEP) ? n : DEEP);
    chk("load_ovf", ovf, (n > DEEP));
    chk("load_busy_after", busy, 0);
    chk("load_ready_after", s_ready, 1);
  endtask

  // Read command with optional simultaneous load beat that must lose.
  task automatic do_read(input int base, input int len, input bit collide);
    int L;
    L = (len > DEEP) ? DEEP : len;
    rd_start = 1'b1;
    rd_base  = AW'(base);
    rd_len   = (AW+1)'(len);
    if (collide) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      s_last  = 1'b1;
    end
    #1;
    chk("cmd_s_ready", s_ready, 0);
    chk("cmd_wea", ram_wea, 0);
    for (int i = 0; i < L; i++)
      sb.push_back('{d: ref_mem[(base + i) % DEEP], l: (i == L - 1)});
    tick();
    rd_start = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    if (L == 0) begin
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      chk("len0_reb", ram_reb, 0);
      tick();
      chk("len0_done_clr", done, 0);
      chk("len0_reb2", ram_reb, 0);
      return;
    end
    for (int c = 0; c < L; c++) begin
      chk("rd_reb", ram_reb, 1);
      chk("rd_addrb", ram_addrb, (base + c) % DEEP);
      chk("rd_busy", busy, 1);
      chk("rd_done_early", done, 0);
      if (c > 0) chk("rd_m_valid", m_valid, 1);
      tick();
    end
    chk("flush_reb", ram_reb, 0);
    chk("flush_busy", busy, 1);
    chk("flush_m_valid", m_valid, 1);
    chk("flush_m_last", m_last, 1);
    tick();
    chk("rd_done", done, 1);
    chk("rd_busy_end", busy, 0);
    chk("rd_m_valid_end", m_valid, 0);
    tick();
    chk("rd_done_clr", done, 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0;
    for (int i = 0; i < DEEP; i++) begin
      mem[i]     = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end
    #2;
    all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_s_ready", s_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt", loaded_cnt, 0);
    tick();

    // Directed: 5-word load, then checks of the buffer contents.
    do_load(5, 1'b0, 16'h0011);
    for (int i = 0; i < 5; i++) chk("ram_content", mem[i], 16'h0011 + i);
    do_read(1, 3, 1'b0);
    do_read(38, 4, 1'b0);
    do_load(45, 1'b1, '0);
    do_read(38, 4, 1'b0);
    do_read(0, 50, 1'b0);
    do_read(5, 2, 1'b1);
    do_read(7, 0, 1'b0);
    do_load(1, 1'b0, 16'hBEEF);
    chk("ovf_cleared", ovf, 0);
    do_read(0, 2, 1'b0);

    // Randomized loads and reads.
    for (int it = 0; it < 8; it++) begin
      do_load($urandom_range(1, 45), 1'b1, '0);
      repeat ($urandom_range(0, 2)) tick();
      do_read($urandom_range(0, DEEP - 1), $urandom_range(0, 45), ($urandom_range(0, 3) == 0));
      do_read($urandom_range(0, DEEP - 1), $urandom_range(1, 45), 1'b0);
    end

    // Reset two cycles into a 6-word read.
    rd_start = 1'b1; rd_base = AW'(10); rd_len = (AW+1)'(6);
    for (int i = 0; i < 6; i++)
      sb.push_back('{d: ref_mem[(10 + i) % DEEP], l: (i == 5)});
    tick();
    rd_start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    all_zero("mid_rst");
    chk("mid_rst_sb_left", sb.size(), 5);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("post_rst_no_done", done, 0);
      chk("post_rst_no_mvalid", m_valid, 0);
      chk("post_rst_idle", busy, 0);
      tick();
    end
    do_load(3, 1'b1, '0);
    do_read(0, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
